// File: rtl/snn_serial_pkg.sv
// Shared types and constants for the SNN debug serial link (receive and transmit sides).
package snn_serial_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam int DEFAULT_PADDING    = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PAD   = 2'd1,
      SHIFT = 2'd2
   } rx_state_e;

   function automatic int frame_len(input int padding, input int data_width);
      return padding + data_width;
   endfunction

endpackage

// File: rtl/snn_serial_rx_if.sv
// Bundle of the serial-in, parallel-out and status signals of the SNN serial receiver.
interface snn_serial_rx_if
   import snn_serial_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = 8,
   parameter int PTR_WIDTH  = $clog2(DEPTH)
);

   // valid_in qualifies serial_in on every bit cycle of a frame; there is no backpressure.
   // read_en pops the head word at the clock edge when empty is low; it is ignored when empty.
   logic                  serial_in;
   logic                  valid_in;
   logic                  read_en;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  empty;
   logic                  full;
   logic [PTR_WIDTH:0]    count;
   logic                  overrun;
   logic                  frame_error;
   logic                  pad_error;
   rx_state_e             rx_state;

   modport slave (
      input  serial_in, valid_in, read_en,
      output data_out, empty, full, count, overrun, frame_error, pad_error, rx_state
   );

   modport master (
      output serial_in, valid_in, read_en,
      input  data_out, empty, full, count, overrun, frame_error, pad_error, rx_state
   );

endinterface

// File: rtl/snn_rx_fifo.sv
// First-word-fall-through receive FIFO; a push into a full FIFO drops the oldest word.
module snn_rx_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic [PTR_WIDTH:0]    count_o,
   output logic                  overrun_o
);

   localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]    count_q, count_d;
   logic                  overrun_q, overrun_d;
   logic                  empty, full, do_pop;

   assign empty  = (count_q == '0);
   assign full   = (count_q == DEPTH_CNT);
   assign do_pop = pop_i && !empty;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      overrun_d = 1'b0;
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
         end else if (full) begin
            // Oldest word is sacrificed so the newest capture is never lost.
            rd_ptr_d  = rd_ptr_q + PTR_WIDTH'(1);
            overrun_d = 1'b1;
         end else begin
            count_d = count_q + (PTR_WIDTH+1)'(1);
         end
      end else if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
         count_d  = count_q - (PTR_WIDTH+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign data_o    = empty ? '0 : mem_q[rd_ptr_q];
   assign empty_o   = empty;
   assign full_o    = full;
   assign count_o   = count_q;
   assign overrun_o = overrun_q;

endmodule

// File: rtl/snn_serial_rx.sv
// Deserializer for the SNN debug serial link: MSB-first frames with optional zero padding.
module snn_serial_rx
   import snn_serial_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int PADDING    = DEFAULT_PADDING,
   parameter int DEPTH      = 8,
   parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst_i,
   snn_serial_rx_if.slave bus
);

   localparam int FL    = frame_len(PADDING, DATA_WIDTH);
   localparam int CNT_W = (FL > 1) ? $clog2(FL) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FL - 1);
   localparam logic [CNT_W-1:0] MSB_IDX  = CNT_W'(DATA_WIDTH - 1);

   rx_state_e             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, cur_idx;
   logic [DATA_WIDTH-1:0] shift_q, shift_d, push_word;
   logic                  frame_error_q, frame_error_d;
   logic                  pad_error_q, pad_error_d;
   logic                  push;

   // In IDLE the incoming bit is bit 0 of a new frame, so it carries the top counter value.
   assign cur_idx = (state_q == IDLE) ? LAST_IDX : cnt_q;

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         shift_q       <= '0;
         frame_error_q <= 1'b0;
         pad_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         shift_q       <= shift_d;
         frame_error_q <= frame_error_d;
         pad_error_q   <= pad_error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (bus.valid_in) begin
         if (cur_idx <= MSB_IDX) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], bus.serial_in};
         end
         if (cur_idx == '0) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d   = cur_idx - CNT_W'(1);
            state_d = (cnt_d > MSB_IDX) ? PAD : SHIFT;
         end
      end else if (state_q != IDLE) begin
         state_d = IDLE;
         cnt_d   = '0;
         shift_d = '0;
      end
   end

   always_comb begin
      push          = 1'b0;
      push_word     = {shift_q[DATA_WIDTH-2:0], bus.serial_in};
      frame_error_d = 1'b0;
      pad_error_d   = pad_error_q;
      if (bus.valid_in) begin
         if ((cur_idx > MSB_IDX) && bus.serial_in) begin
            pad_error_d = 1'b1;
         end
         push = (cur_idx == '0);
      end else if (state_q != IDLE) begin
         frame_error_d = 1'b1;
      end
   end

   snn_rx_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .PTR_WIDTH  (PTR_WIDTH)
   ) u_fifo (
      .clk         (clk),
      .rst_i       (rst_i),
      .push_i      (push),
      .push_data_i (push_word),
      .pop_i       (bus.read_en),
      .data_o      (bus.data_out),
      .empty_o     (bus.empty),
      .full_o      (bus.full),
      .count_o     (bus.count),
      .overrun_o   (bus.overrun)
   );

   assign bus.frame_error = frame_error_q;
   assign bus.pad_error   = pad_error_q;
   assign bus.rx_state    = state_q;

endmodule

// File: tb/tb_snn_serial_rx.sv
// Bench for snn_serial_rx: two instances (no padding / depth 4, two pad bits / depth 8).
module tb_snn_serial_rx;
   import snn_serial_pkg::*;

   localparam int DW      = 16;
   localparam int DEPTH_A = 4;
   localparam int DEPTH_B = 8;
   localparam int FL_A    = 16;
   localparam int FL_B    = 18;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          sin [2];
   logic          vin [2];
   logic          ren [2];
   logic [DW-1:0] dout [2];
   logic          emp [2];
   logic          ful [2];
   logic [3:0]    cnt [2];
   logic          ovr [2];
   logic          ferr [2];
   logic          perr [2];
   rx_state_e     st [2];

   snn_serial_rx_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH_A)) if_a ();
   snn_serial_rx_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH_B)) if_b ();

   snn_serial_rx #(.DATA_WIDTH(DW), .PADDING(0), .DEPTH(DEPTH_A)) dut_a (
      .clk   (clk),
      .rst_i (rst),
      .bus   (if_a)
   );

   snn_serial_rx #(.DATA_WIDTH(DW), .PADDING(2), .DEPTH(DEPTH_B)) dut_b (
      .clk   (clk),
      .rst_i (rst),
      .bus   (if_b)
   );

   assign if_a.serial_in = sin[0];
   assign if_a.valid_in  = vin[0];
   assign if_a.read_en   = ren[0];
   assign if_b.serial_in = sin[1];
   assign if_b.valid_in  = vin[1];
   assign if_b.read_en   = ren[1];
   assign dout[0] = if_a.data_out;
   assign dout[1] = if_b.data_out;
   assign emp[0]  = if_a.empty;
   assign emp[1]  = if_b.empty;
   assign ful[0]  = if_a.full;
   assign ful[1]  = if_b.full;
   assign cnt[0]  = {1'b0, if_a.count};
   assign cnt[1]  = if_b.count;
   assign ovr[0]  = if_a.overrun;
   assign ovr[1]  = if_b.overrun;
   assign ferr[0] = if_a.frame_error;
   assign ferr[1] = if_b.frame_error;
   assign perr[0] = if_a.pad_error;
   assign perr[1] = if_b.pad_error;
   assign st[0]   = if_a.rx_state;
   assign st[1]   = if_b.rx_state;

   int n_checks = 0;
   int n_pass   = 0;

   // Word-level reference: queue of words the receiver should hold, plus sticky pad flag.
   logic [DW-1:0] exp_q[$];
   bit            exp_pad;

   task automatic model_push(input int depth, input logic [DW-1:0] w, input bit pop, output bit ovf);
      ovf = 1'b0;
      if (pop && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
      end else if (exp_q.size() == depth) begin
         void'(exp_q.pop_front());
         ovf = 1'b1;
      end
      exp_q.push_back(w);
   endtask

   task automatic model_pop();
      if (exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   function automatic logic [DW-1:0] exp_head();
      return (exp_q.size() > 0) ? exp_q[0] : '0;
   endfunction

   task automatic cyc(input int d, input bit s, input bit v, input bit r);
      sin[d] = s;
      vin[d] = v;
      ren[d] = r;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_bits(input int d, input logic [17:0] f, input int nbits, input bit ren_last);
      int fl;
      fl = (d == 0) ? FL_A : FL_B;
      for (int i = 0; i < nbits; i++) begin
         cyc(d, f[fl-1-i], 1'b1, ren_last && (i == nbits - 1));
      end
   endtask

   task automatic do_reset();
      for (int d = 0; d < 2; d++) begin
         sin[d] = 1'b0;
         vin[d] = 1'b0;
         ren[d] = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_pad = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int d = 0; d < 2; d++) begin
         n_checks++; if (emp[d] !== 1'b1) $display("FAIL reset_empty[%0d]: got %b want 1", d, emp[d]); else n_pass++;
         n_checks++; if (ful[d] !== 1'b0) $display("FAIL reset_full[%0d]: got %b want 0", d, ful[d]); else n_pass++;
         n_checks++; if (cnt[d] !== 4'd0) $display("FAIL reset_count[%0d]: got %0d want 0", d, cnt[d]); else n_pass++;
         n_checks++; if (dout[d] !== 16'h0000) $display("FAIL reset_data[%0d]: got %h want 0000", d, dout[d]); else n_pass++;
         n_checks++; if ({ovr[d], ferr[d], perr[d]} !== 3'b000) $display("FAIL reset_flags[%0d]: got %b want 000", d, {ovr[d], ferr[d], perr[d]}); else n_pass++;
         n_checks++; if (st[d] !== IDLE) $display("FAIL reset_state[%0d]: got %0d want IDLE", d, st[d]); else n_pass++;
      end
   endtask

   task automatic test_basic();
      logic [DW-1:0] w;
      bit o;
      do_reset();
      send_bits(0, {2'b00, 16'hA5C3}, 16, 1'b0);
      model_push(DEPTH_A, 16'hA5C3, 1'b0, o);
      n_checks++; if (dout[0] !== exp_head()) $display("FAIL basic_data: got %h want %h", dout[0], exp_head()); else n_pass++;
      n_checks++; if (emp[0] !== 1'b0) $display("FAIL basic_empty: got %b want 0", emp[0]); else n_pass++;
      n_checks++; if (cnt[0] !== exp_q.size()) $display("FAIL basic_count: got %0d want %0d", cnt[0], exp_q.size()); else n_pass++;
      cyc(0, 1'b0, 1'b0, 1'b1);
      model_pop();
      n_checks++; if (emp[0] !== 1'b1) $display("FAIL basic_pop_empty: got %b want 1", emp[0]); else n_pass++;
      n_checks++; if (dout[0] !== exp_head()) $display("FAIL basic_pop_data: got %h want %h", dout[0], exp_head()); else n_pass++;
      for (int k = 0; k < 4; k++) begin
         w = DW'($urandom);
         send_bits(0, {2'b00, w}, 16, 1'b0);
         model_push(DEPTH_A, w, 1'b0, o);
         cyc(0, 1'b0, 1'b0, 1'b0);
         n_checks++; if (dout[0] !== exp_head()) $display("FAIL basic_rand_data: got %h want %h", dout[0], exp_head()); else n_pass++;
         n_checks++; if (ferr[0] !== 1'b0) $display("FAIL basic_rand_ferr: got %b want 0", ferr[0]); else n_pass++;
         cyc(0, 1'b0, 1'b0, 1'b1);
         model_pop();
      end
   endtask

   task automatic test_padding();
      bit o;
      do_reset();
      send_bits(1, {2'b00, 16'h1234}, 18, 1'b0);
      model_push(DEPTH_B, 16'h1234, 1'b0, o);
      n_checks++; if (dout[1] !== exp_head()) $display("FAIL pad_clean_data: got %h want %h", dout[1], exp_head()); else n_pass++;
      n_checks++; if (perr[1] !== exp_pad) $display("FAIL pad_clean_flag: got %b want %b", perr[1], exp_pad); else n_pass++;
      cyc(1, 1'b0, 1'b0, 1'b1);
      model_pop();
      send_bits(1, {2'b10, 16'h1234}, 18, 1'b0);
      exp_pad = 1'b1;
      model_push(DEPTH_B, 16'h1234, 1'b0, o);
      n_checks++; if (dout[1] !== exp_head()) $display("FAIL pad_bad_data: got %h want %h", dout[1], exp_head()); else n_pass++;
      n_checks++; if (perr[1] !== exp_pad) $display("FAIL pad_bad_flag: got %b want %b", perr[1], exp_pad); else n_pass++;
      cyc(1, 1'b0, 1'b0, 1'b1);
      model_pop();
      for (int k = 0; k < 3; k++) cyc(1, 1'b0, 1'b0, 1'b0);
      n_checks++; if (perr[1] !== exp_pad) $display("FAIL pad_sticky: got %b want %b", perr[1], exp_pad); else n_pass++;
      n_checks++; if (emp[1] !== 1'b1) $display("FAIL pad_empty: got %b want 1", emp[1]); else n_pass++;
   endtask

   task automatic test_frame_error();
      bit o;
      do_reset();
      send_bits(0, {2'b00, DW'($urandom)}, 7, 1'b0);
      cyc(0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (ferr[0] !== 1'b1) $display("FAIL ferr_pulse: got %b want 1", ferr[0]); else n_pass++;
      n_checks++; if (cnt[0] !== 4'd0) $display("FAIL ferr_no_push: got %0d want 0", cnt[0]); else n_pass++;
      cyc(0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (ferr[0] !== 1'b0) $display("FAIL ferr_one_cycle: got %b want 0", ferr[0]); else n_pass++;
      send_bits(0, {2'b00, 16'h00FF}, 16, 1'b0);
      model_push(DEPTH_A, 16'h00FF, 1'b0, o);
      cyc(0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (cnt[0] !== exp_q.size()) $display("FAIL ferr_count: got %0d want %0d", cnt[0], exp_q.size()); else n_pass++;
      n_checks++; if (dout[0] !== exp_head()) $display("FAIL ferr_data: got %h want %h", dout[0], exp_head()); else n_pass++;
      n_checks++; if (ferr[0] !== 1'b0) $display("FAIL ferr_quiet: got %b want 0", ferr[0]); else n_pass++;
      send_bits(1, {2'b00, 16'h0000}, 1, 1'b0);
      cyc(1, 1'b0, 1'b0, 1'b0);
      n_checks++; if (ferr[1] !== 1'b1) $display("FAIL ferr_in_pad: got %b want 1", ferr[1]); else n_pass++;
   endtask

   task automatic run_overflow(input bit pop_on_fifth, input string tag);
      bit o;
      do_reset();
      for (int k = 1; k <= 5; k++) begin
         send_bits(0, 18'(k), 16, pop_on_fifth && (k == 5));
         model_push(DEPTH_A, DW'(k), pop_on_fifth && (k == 5), o);
         n_checks++; if (ovr[0] !== o) $display("FAIL %s_overrun_w%0d: got %b want %b", tag, k, ovr[0], o); else n_pass++;
         n_checks++; if (cnt[0] !== exp_q.size()) $display("FAIL %s_count_w%0d: got %0d want %0d", tag, k, cnt[0], exp_q.size()); else n_pass++;
      end
      cyc(0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (ovr[0] !== 1'b0) $display("FAIL %s_overrun_clear: got %b want 0", tag, ovr[0]); else n_pass++;
      n_checks++; if (ful[0] !== (exp_q.size() == DEPTH_A)) $display("FAIL %s_full: got %b want %b", tag, ful[0], exp_q.size() == DEPTH_A); else n_pass++;
      while (exp_q.size() > 0) begin
         n_checks++; if (dout[0] !== exp_head()) $display("FAIL %s_pop_data: got %h want %h", tag, dout[0], exp_head()); else n_pass++;
         cyc(0, 1'b0, 1'b0, 1'b1);
         model_pop();
      end
      n_checks++; if (emp[0] !== 1'b1) $display("FAIL %s_drained: got %b want 1", tag, emp[0]); else n_pass++;
   endtask

   task automatic test_back_to_back();
      run_overflow(1'b0, "b2b");
   endtask

   task automatic test_full_pop();
      run_overflow(1'b1, "fullpop");
   endtask

   task automatic test_reset_mid_frame();
      bit o;
      do_reset();
      send_bits(0, {2'b00, DW'($urandom)}, 9, 1'b0);
      do_reset();
      n_checks++; if (cnt[0] !== 4'd0) $display("FAIL rstmid_count: got %0d want 0", cnt[0]); else n_pass++;
      send_bits(0, {2'b00, 16'hBEEF}, 16, 1'b0);
      model_push(DEPTH_A, 16'hBEEF, 1'b0, o);
      cyc(0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (cnt[0] !== exp_q.size()) $display("FAIL rstmid_count2: got %0d want %0d", cnt[0], exp_q.size()); else n_pass++;
      n_checks++; if (dout[0] !== exp_head()) $display("FAIL rstmid_data: got %h want %h", dout[0], exp_head()); else n_pass++;
      n_checks++; if ({ovr[0], ferr[0], perr[0]} !== 3'b000) $display("FAIL rstmid_flags: got %b want 000", {ovr[0], ferr[0], perr[0]}); else n_pass++;
   endtask

   task automatic test_random_stream();
      logic [DW-1:0] w;
      logic [1:0]    pad;
      bit            r, o;
      int            gaps;
      do_reset();
      for (int k = 0; k < 24; k++) begin
         w   = DW'($urandom);
         pad = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         r   = 1'($urandom_range(0, 1));
         send_bits(1, {pad, w}, 18, r);
         if (pad != 2'b00) exp_pad = 1'b1;
         model_push(DEPTH_B, w, r, o);
         n_checks++; if (ovr[1] !== o) $display("FAIL rand_overrun_%0d: got %b want %b", k, ovr[1], o); else n_pass++;
         n_checks++; if (cnt[1] !== exp_q.size()) $display("FAIL rand_count_%0d: got %0d want %0d", k, cnt[1], exp_q.size()); else n_pass++;
         n_checks++; if (dout[1] !== exp_head()) $display("FAIL rand_data_%0d: got %h want %h", k, dout[1], exp_head()); else n_pass++;
         n_checks++; if (perr[1] !== exp_pad) $display("FAIL rand_pad_%0d: got %b want %b", k, perr[1], exp_pad); else n_pass++;
         gaps = $urandom_range(0, 2);
         for (int g = 0; g < gaps; g++) begin
            r = 1'($urandom_range(0, 1));
            cyc(1, 1'b0, 1'b0, r);
            if (r) model_pop();
            n_checks++; if (cnt[1] !== exp_q.size()) $display("FAIL rand_gap_count_%0d: got %0d want %0d", k, cnt[1], exp_q.size()); else n_pass++;
         end
      end
      cyc(1, 1'b0, 1'b0, 1'b0);
      n_checks++; if (ful[1] !== (exp_q.size() == DEPTH_B)) $display("FAIL rand_full: got %b want %b", ful[1], exp_q.size() == DEPTH_B); else n_pass++;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         sin[d] = 1'b0;
         vin[d] = 1'b0;
         ren[d] = 1'b0;
      end
      @(negedge clk);
      test_reset();
      test_basic();
      test_padding();
      test_frame_error();
      test_back_to_back();
      test_full_pop();
      test_reset_mid_frame();
      test_random_stream();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/snn_serial_rx.md
Name: snn_serial_rx

Overview:
Receive end of the SNN debug serial link. Deserializes the MSB-first bit stream produced by the SNN debug FIFO transmitter (optional leading zero padding, per-bit valid) back into DATA_WIDTH-bit words. Buffers the words in a small FIFO with a first-word-fall-through read port. Sits on the host/debug-capture side, or in loopback test harnesses, and presents words to a parallel consumer.

Parameters:
- DATA_WIDTH, 16: payload bits per frame.
- PADDING, 0: zero bits preceding the payload in each frame; must match the transmitter.
- DEPTH, 8: receive FIFO words; power of two, ≥2.
- PTR_WIDTH, $clog2(DEPTH): FIFO pointer width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- serial_in  in  1  serial data bit.
- valid_in  in  1  high for every bit cycle of a frame.
- read_en  in  1  pop the head word; ignored when empty.
- data_out  out  DATA_WIDTH  head word, first-word-fall-through; 0 when empty.
- empty  out  1  FIFO holds 0 words.
- full  out  1  FIFO holds DEPTH words.
- count  out  PTR_WIDTH+1  words held.
- overrun  out  1  one-cycle pulse: oldest word overwritten.
- frame_error  out  1  one-cycle pulse: valid_in dropped mid-frame.
- pad_error  out  1  sticky: a padding bit was sampled as 1; cleared only by reset.

Behaviour:
- Reset (rst_i sampled high): FSM→IDLE; pointers, count, shift register and bit counter cleared; all flag outputs 0; empty=1; full=0; data_out=0. Reset mid-frame discards the partial word. Memory contents are not cleared.
- Frame length: FRAME_LEN = PADDING + DATA_WIDTH bit cycles. The bit counter counts FRAME_LEN-1 down to 0.
- FSM states:
  - IDLE: the first cycle with valid_in=1 is bit 0 of a frame. Go to PAD if PADDING>0, else SHIFT; the bit is consumed in that same cycle.
  - PAD: consume PADDING bits. Each bit must be 0; any 1 sets pad_error. The word is still received.
  - SHIFT: shift serial_in into the LSB. The first payload bit is the word MSB.
- Last payload bit (counter 0, valid_in=1): the word {shift_reg[DATA_WIDTH-2:0], serial_in} is pushed at that same edge.
  - empty deasserts and data_out shows the word in the cycle after the last bit.
  - If valid_in is still 1 on the next cycle, a new frame starts there with no gap. Otherwise → IDLE.
- valid_in=0 while in PAD or SHIFT: discard the partial word, pulse frame_error for one cycle, → IDLE. No push.
- FIFO push/pop at one edge:
  - Push, not full: write, wr_ptr+1, count+1.
  - Push when full, no pop: overwrite the oldest word; wr_ptr+1, rd_ptr+1, count unchanged, pulse overrun.
  - Push and pop together, not empty: both pointers advance, count unchanged, no overrun (even when full).
  - Push and pop together when empty: push only; the pop is ignored.
  - Pop when empty: no effect.
- Pointers wrap modulo DEPTH. full = (count==DEPTH); empty = (count==0); both derived from count.
- data_out = mem[rd_ptr] when not empty, else 0. It is combinational from registered state.

Decomposition:
- Package snn_serial_pkg:
  - rx_state_e enum {IDLE, PAD, SHIFT}.
  - FRAME_LEN helper function (PADDING+DATA_WIDTH).
  - Shared defaults for DATA_WIDTH/PADDING, reused by the transmit side.
- Sub-module snn_rx_fifo: synchronous FWFT FIFO with drop-oldest overwrite and overrun pulse, instantiated once.
- The deserializer FSM, shift register and bit counter stay in snn_serial_rx.

Test Plan:
- Basic frame (DATA_WIDTH=16, PADDING=0): send 0xA5C3 MSB-first over 16 valid cycles → next cycle data_out=0xA5C3, empty=0, count=1; read_en 1 cycle → empty=1, data_out=0.
- Padding (PADDING=2): send bits 0,0 then 0x1234 over 18 cycles → data_out=0x1234, pad_error=0. Repeat with the first pad bit =1 → word still 0x1234, pad_error=1 and stays 1.
- Framing error: drop valid_in after 7 payload bits, then send 0x00FF → frame_error pulses once, count=1, data_out=0x00FF.
- Back-to-back and overflow (DEPTH=4): send 0x0001..0x0005 with valid_in continuously high for 80 cycles → overrun pulses once after the 5th word; count=4; pops return 0x0002, 0x0003, 0x0004, 0x0005.
- Full with simultaneous pop (DEPTH=4): hold read_en=1 on the push cycle of word 5 → no overrun; pops return 0x0002..0x0005.
- Reset mid-frame: assert rst_i after 9 payload bits, then send 0xBEEF → only 0xBEEF is received; all flags 0.
